// File: rtl/cmd_to_gcode_pkg.sv
// cmd_to_gcode_pkg: op encoding, ASCII constants, field enum and shared cmd-to-code lookup
package cmd_to_gcode_pkg;
   localparam int OP_CMD_BITS = 3;
   typedef enum logic [OP_CMD_BITS-1:0] {
      OP_G00 = 3'd0, OP_G01 = 3'd1, OP_G02 = 3'd2, OP_G03 = 3'd3,
      OP_G90 = 3'd4, OP_G91 = 3'd5, OP_UNKNOWN = 3'd7
   } op_cmd_t;
   localparam logic [7:0] A_G = 8'h47, A_X = 8'h58, A_Y = 8'h59, A_I = 8'h49, A_J = 8'h4A;
   localparam logic [7:0] A_SP = 8'h20, A_MINUS = 8'h2D, A_STAR = 8'h2A, A_ZERO = 8'h30, A_LF = 8'h0A;
   typedef enum logic [2:0] {F_X, F_Y, F_I, F_J, F_CK} field_t;
   function automatic logic cmd_known(input logic [OP_CMD_BITS-1:0] c);
      return c <= OP_G91;
   endfunction
   function automatic logic [15:0] cmd_code(input logic [OP_CMD_BITS-1:0] c);
      return {c[2] ? 8'h39 : A_ZERO, A_ZERO | {6'd0, c[1:0]}};
   endfunction
   function automatic logic [7:0] field_letter(input field_t f);
      return f == F_X ? A_X : f == F_Y ? A_Y : f == F_I ? A_I : f == F_J ? A_J : A_STAR;
   endfunction
   function automatic logic [7:0] dchar(input logic [3:0] d);
      return A_ZERO | {4'd0, d};
   endfunction
endpackage

// File: rtl/cmd_to_gcode_dec_digitizer.sv
// cmd_to_gcode_dec_digitizer: signed value to decimal digits (LSD first), one digit per cycle
module cmd_to_gcode_dec_digitizer
   import cmd_to_gcode_pkg::*;
#(
   parameter int COORD_BITS = 16,
   parameter int MAX_DIGITS = 5,
   parameter int DW = $clog2(MAX_DIGITS + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic signed [COORD_BITS-1:0] value,
   output logic                         neg,
   output logic [DW-1:0]                ndig,
   output logic [MAX_DIGITS-1:0][3:0]   dig,
   output logic                         done
);
   localparam logic [COORD_BITS:0] TEN = (COORD_BITS + 1)'(10);
   logic [COORD_BITS:0] absv, mag, src, q;
   logic [3:0] r;
   assign absv = value[COORD_BITS-1] ? -{value[COORD_BITS-1], value} : {value[COORD_BITS-1], value};
   assign src = load ? absv : mag;
   assign q = src / TEN;
   assign r = 4'(src % TEN);
   // first digit comes straight from the loaded value, later digits from the running quotient
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         neg <= 1'b0;
         ndig <= '0;
         dig <= '0;
         mag <= '0;
         done <= 1'b1;
      end else if (load) begin
         neg <= value[COORD_BITS-1];
         dig[0] <= r;
         mag <= q;
         ndig <= DW'(1);
         done <= q == '0;
      end else if (!done) begin
         dig[ndig] <= r;
         mag <= q;
         ndig <= ndig + 1'b1;
         done <= q == '0;
      end
endmodule

// File: rtl/cmd_to_gcode.sv
// cmd_to_gcode: op command to ASCII G-code line serializer; CMD_TO_GCODE_CHECKSUM_EN adds '*<xor>' before LF
module cmd_to_gcode
   import cmd_to_gcode_pkg::*;
#(
   parameter int COORD_BITS = 16,
   parameter int MAX_DIGITS = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [OP_CMD_BITS-1:0]       cmd,
   input  logic signed [COORD_BITS-1:0] x,
   input  logic signed [COORD_BITS-1:0] y,
   input  logic signed [COORD_BITS-1:0] i,
   input  logic signed [COORD_BITS-1:0] j,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [7:0]                   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         err
);
   localparam int DW = $clog2(MAX_DIGITS + 1);
   typedef enum logic [3:0] {IDLE, CHAR_G, CODE_HI, CODE_LO, SPACE, LETTER, CONV, SIGN, DIGITS, NEWLINE, DONE} state_t;
`ifdef CMD_TO_GCODE_CHECKSUM_EN
   localparam state_t TAIL = LETTER;
   localparam logic [7:0] TAIL_B = A_STAR;
   logic [7:0] ck;
`else
   localparam state_t TAIL = NEWLINE;
   localparam logic [7:0] TAIL_B = A_LF;
`endif
   state_t state;
   field_t field, nfield;
   logic [OP_CMD_BITS-1:0] c;
   logic signed [COORD_BITS-1:0] rx, ry, ri, rj, val, ckv;
   logic [DW-1:0] didx, ndig;
   logic [MAX_DIGITS-1:0][3:0] dig;
   logic [15:0] code;
   logic xfer, load, neg, done, arc;
   assign xfer = out_valid && out_ready;
   assign load = state == LETTER && xfer;
   assign code = cmd_code(c);
   assign arc = c == OP_G02 || c == OP_G03;
   assign nfield = field == F_X ? F_Y : (field == F_Y && arc) ? F_I : field == F_I ? F_J : F_CK;
`ifdef CMD_TO_GCODE_CHECKSUM_EN
   assign ckv = COORD_BITS'(ck);
`else
   assign ckv = '0;
`endif
   assign val = field == F_X ? rx : field == F_Y ? ry : field == F_I ? ri : field == F_J ? rj : ckv;
   cmd_to_gcode_dec_digitizer #(.COORD_BITS(COORD_BITS), .MAX_DIGITS(MAX_DIGITS), .DW(DW)) u_dig (
      .clk(clk), .reset(reset), .load(load), .value(val),
      .neg(neg), .ndig(ndig), .dig(dig), .done(done)
   );
`ifdef CMD_TO_GCODE_CHECKSUM_EN
   // running XOR of every byte from 'G' through the last field digit
   always_ff @(posedge clk or posedge reset)
      if (reset) ck <= '0;
      else if (state == IDLE && in_valid && in_ready) ck <= '0;
      else if (xfer && field != F_CK && state != NEWLINE) ck <= ck ^ out_data;
`endif
   // line sequencer; out_data/out_valid are loaded on the transfer that leaves each state
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         field <= F_X;
         c <= '0;
         rx <= '0;
         ry <= '0;
         ri <= '0;
         rj <= '0;
         didx <= '0;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         out_data <= '0;
         busy <= 1'b0;
         err <= 1'b0;
      end else
         case (state)
            IDLE:
               if (in_valid && in_ready) begin
                  c <= cmd;
                  rx <= x;
                  ry <= y;
                  ri <= i;
                  rj <= j;
                  field <= F_X;
                  in_ready <= 1'b0;
                  state <= cmd_known(cmd) ? CHAR_G : DONE;
                  out_valid <= cmd_known(cmd);
                  out_data <= A_G;
                  busy <= cmd_known(cmd);
                  err <= !cmd_known(cmd);
               end else in_ready <= 1'b1;
            CHAR_G: if (xfer) begin
               state <= CODE_HI;
               out_data <= code[15:8];
            end
            CODE_HI: if (xfer) begin
               state <= CODE_LO;
               out_data <= code[7:0];
            end
            CODE_LO: if (xfer) begin
               state <= c < OP_G90 ? SPACE : TAIL;
               out_data <= c < OP_G90 ? A_SP : TAIL_B;
               field <= c < OP_G90 ? F_X : F_CK;
            end
            SPACE: if (xfer) begin
               state <= LETTER;
               out_data <= field_letter(field);
            end
            LETTER: if (xfer) begin
               state <= CONV;
               out_valid <= 1'b0;
            end
            CONV: if (done) begin
               didx <= ndig - 1'b1;
               state <= neg ? SIGN : DIGITS;
               out_valid <= 1'b1;
               out_data <= neg ? A_MINUS : dchar(dig[ndig - 1'b1]);
            end
            SIGN: if (xfer) begin
               state <= DIGITS;
               out_data <= dchar(dig[didx]);
            end
            DIGITS: if (xfer) begin
               if (didx != '0) begin
                  didx <= didx - 1'b1;
                  out_data <= dchar(dig[didx - 1'b1]);
               end else if (field == F_CK) begin
                  state <= NEWLINE;
                  out_data <= A_LF;
               end else begin
                  state <= nfield == F_CK ? TAIL : SPACE;
                  out_data <= nfield == F_CK ? TAIL_B : A_SP;
                  field <= nfield;
               end
            end
            NEWLINE: if (xfer) begin
               state <= DONE;
               out_valid <= 1'b0;
               busy <= 1'b0;
            end
            DONE: begin
               state <= IDLE;
               err <= 1'b0;
               in_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_cmd_to_gcode.sv
// tb_cmd_to_gcode: directed vector table plus handshake/reset/unknown-cmd sequences
module tb_cmd_to_gcode;
   import cmd_to_gcode_pkg::*;
   logic clk = 1'b0, reset = 1'b1;
   logic [OP_CMD_BITS-1:0] cmd = '0;
   logic signed [15:0] x = '0, y = '0, i = '0, j = '0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy, err;
   logic [7:0] out_data;
   int checks = 0, errors = 0;
   logic [7:0] expq[$];
   typedef struct {
      op_cmd_t cmd;
      logic signed [15:0] x, y, i, j;
      bit stall;
      string line;
   } vec_t;
   vec_t vt[6];

   cmd_to_gcode dut (
      .clk(clk), .reset(reset), .cmd(cmd), .x(x), .y(y), .i(i), .j(j),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_line(input string s);
      logic [7:0] cs;
      cs = '0;
      for (int k = 0; k < s.len(); k++) begin
         expq.push_back(s[k]);
         cs = cs ^ s[k];
      end
`ifdef CMD_TO_GCODE_CHECKSUM_EN
      expq.push_back(8'h2A);
      if (cs >= 8'd100) expq.push_back(8'h30 + cs / 8'd100);
      if (cs >= 8'd10) expq.push_back(8'h30 + (cs / 8'd10) % 8'd10);
      expq.push_back(8'h30 + cs % 8'd10);
`endif
      expq.push_back(8'h0A);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] hd, eb;
      bit held, lf;
      int got, cyc;
      hd = '0; held = 0; lf = 0; got = 0; cyc = 0;
      expq.delete();
      push_line(v.line);
      @(negedge clk);
      chk(in_ready, "in_ready_idle", 32'(in_ready), 1);
      cmd = v.cmd; x = v.x; y = v.y; i = v.i; j = v.j;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk(out_valid && out_data == 8'h47, "first_byte_G", 32'({out_valid, out_data}), 32'h147);
      chk(busy, "busy_on_accept", 32'(busy), 1);
      while (!lf && cyc < 400) begin
         if (held) chk(out_valid && out_data == hd, "hold_stable", 32'({out_valid, out_data}), 32'({1'b1, hd}));
         out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            eb = got < expq.size() ? expq[got] : 8'hFF;
            chk(out_data == eb, "line_byte", 32'(out_data), 32'(eb));
            got++;
            lf = out_data == 8'h0A;
         end
         held = out_valid && !out_ready;
         hd = out_data;
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b1;
      chk(lf, "line_complete", 32'(cyc), 400);
      chk(got == expq.size(), "byte_count", 32'(got), 32'(expq.size()));
      chk(!busy && !out_valid, "busy_low_after_lf", 32'({busy, out_valid}), 0);
      @(negedge clk);
      chk(in_ready, "in_ready_return", 32'(in_ready), 1);
   endtask

   initial begin
      int n, cyc, acc, got, lfs;
      logic [7:0] eb;
      vt[0] = '{OP_G01, 16'sd100, -16'sd25, 16'sd0, 16'sd0, 1'b0, "G01 X100 Y-25"};
      vt[1] = '{OP_G02, 16'sd0, 16'sd5, 16'sh8000, 16'sd1, 1'b0, "G02 X0 Y5 I-32768 J1"};
      vt[2] = '{OP_G00, 16'sd7, 16'sd7, 16'sd0, 16'sd0, 1'b1, "G00 X7 Y7"};
      vt[3] = '{OP_G03, 16'sd32767, -16'sd1, 16'sd10, -16'sd10, 1'b1, "G03 X32767 Y-1 I10 J-10"};
      vt[4] = '{OP_G91, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b0, "G91"};
      vt[5] = '{OP_G01, -16'sd9, 16'sd0, 16'sd0, 16'sd0, 1'b0, "G01 X-9 Y0"};
      repeat (2) @(negedge clk);
      chk(!out_valid && out_data == 8'h00, "reset_out", 32'({out_valid, out_data}), 0);
      chk(!busy && !err && !in_ready, "reset_flags", 32'({busy, err, in_ready}), 0);
      reset = 1'b0;
      @(negedge clk);
      chk(in_ready, "in_ready_after_reset", 32'(in_ready), 1);
      foreach (vt[k]) run_vec(vt[k]);
      expq.delete();
      push_line("G90");
      push_line("G91");
      cmd = OP_G90; in_valid = 1'b1; acc = 0; got = 0; lfs = 0; cyc = 0;
      while (got < expq.size() && cyc < 100) begin
         if (out_valid) chk(!in_ready, "in_ready_low_busy", 32'(in_ready), 0);
         if (out_valid && out_ready) begin
            eb = expq[got];
            chk(out_data == eb, "b2b_byte", 32'(out_data), 32'(eb));
            if (out_data == 8'h0A) lfs++;
            got++;
         end
         if (in_valid && in_ready) begin
            chk(lfs == acc, "accept_after_lf", 32'(lfs), 32'(acc));
            acc++;
         end
         @(negedge clk);
         cyc++;
         cmd = acc >= 1 ? OP_G91 : OP_G90;
         in_valid = acc < 2;
      end
      in_valid = 1'b0;
      chk(got == expq.size() && acc == 2, "b2b_complete", 32'(got), 32'(expq.size()));
      repeat (2) @(negedge clk);
      cmd = OP_UNKNOWN; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk(err && !out_valid, "unknown_err_pulse", 32'({err, out_valid}), 32'h2);
      @(negedge clk);
      chk(!err && !out_valid, "unknown_err_one_cycle", 32'({err, out_valid}), 0);
      chk(in_ready, "unknown_back_idle", 32'(in_ready), 1);
      cmd = OP_G01; x = 16'sd12345; y = 16'sd1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0; cyc = 0;
      while (n < 7 && cyc < 50) begin
         if (out_valid && out_ready) n++;
         @(negedge clk);
         cyc++;
      end
      chk(n == 7, "mid_line_reached", 32'(n), 7);
      reset = 1'b1;
      #1;
      chk(!out_valid && !busy && !in_ready, "reset_abort", 32'({out_valid, busy, in_ready}), 0);
      @(negedge clk);
      reset = 1'b0;
      run_vec('{OP_G01, 16'sd1, -16'sd2, 16'sd0, 16'sd0, 1'b0, "G01 X1 Y-2"});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
